// File: rtl/rename_stage.sv
// ============================================================================
//  Module   : rename_stage
//  Purpose  : Register-rename stage. Maps architectural sources through a
//             32-entry RAT, allocates physical destinations from a free-list
//             FIFO and presents the result on a registered valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rename_stage #(
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        srcReg1,
  input  logic [4:0]        srcReg2,
  input  logic [4:0]        destReg,
  input  logic              regWrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_psrc1,
  output logic [PREG_W-1:0] out_psrc2,
  output logic [PREG_W-1:0] out_pdst,
  output logic [PREG_W-1:0] out_old_pdst,
  output logic              out_has_dst,
  input  logic              retire_valid,
  input  logic [PREG_W-1:0] retire_pdst,
  output logic [PREG_W:0]   free_count,
  output logic              fl_overflow
);

  localparam int ARCH_REGS = 32;

  // Architectural state
  logic [PREG_W-1:0] rat_q [ARCH_REGS];
  logic [PREG_W-1:0] rat_d [ARCH_REGS];
  logic [PREG_W-1:0] fl_q  [NUM_PREGS];
  logic [PREG_W-1:0] fl_d  [NUM_PREGS];
  logic [PREG_W-1:0] head_q, head_d;
  logic [PREG_W-1:0] tail_q, tail_d;
  logic [PREG_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  // Output register
  logic              valid_q, valid_d;
  logic [PREG_W-1:0] psrc1_q, psrc1_d;
  logic [PREG_W-1:0] psrc2_q, psrc2_d;
  logic [PREG_W-1:0] pdst_q, pdst_d;
  logic [PREG_W-1:0] old_q, old_d;
  logic              has_dst_q, has_dst_d;

  logic need_dst;
  logic accept;
  logic pop;
  logic push_req;
  logic push;
  logic list_full;

  // Handshake and free-list push/pop qualification
  always_comb begin
    need_dst  = regWrite && (destReg != 5'd0);
    in_ready  = (!valid_q || out_ready) && (!need_dst || (count_q != '0));
    accept    = in_valid && in_ready;
    pop       = accept && need_dst;
    list_full = (count_q == (PREG_W+1)'(NUM_PREGS));
    push_req  = retire_valid && (retire_pdst != '0);
    push      = push_req && !list_full;
  end

  // Next-state for RAT, free list and output register
  always_comb begin
    rat_d     = rat_q;
    fl_d      = fl_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    psrc1_d   = psrc1_q;
    psrc2_d   = psrc2_q;
    pdst_d    = pdst_q;
    old_d     = old_q;
    has_dst_d = has_dst_q;

    if (accept) begin
      // Sources read the pre-update RAT so an instruction never sees its own write.
      valid_d   = 1'b1;
      psrc1_d   = rat_q[srcReg1];
      psrc2_d   = rat_q[srcReg2];
      has_dst_d = need_dst;
      if (need_dst) begin
        pdst_d          = fl_q[head_q];
        old_d           = rat_q[destReg];
        rat_d[destReg]  = fl_q[head_q];
      end else begin
        pdst_d = '0;
        old_d  = '0;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (pop) begin
      head_d = head_q + PREG_W'(1);
    end

    // Push writes the tail slot; a simultaneous pop reads the head slot, which
    // is a different entry whenever the push is allowed, so no bypass occurs.
    if (push) begin
      fl_d[tail_q] = retire_pdst;
      tail_d       = tail_q + PREG_W'(1);
    end
    if (push_req && list_full) begin
      ovf_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PREG_W+1)'(1);
      2'b01:   count_d = count_q - (PREG_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset to identity RAT and full free list
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
      for (int i = 0; i < NUM_PREGS; i++) begin
        fl_q[i] <= (i < NUM_PREGS - ARCH_REGS) ? PREG_W'(i + ARCH_REGS) : '0;
      end
      head_q    <= '0;
      tail_q    <= PREG_W'(NUM_PREGS - ARCH_REGS);
      count_q   <= (PREG_W+1)'(NUM_PREGS - ARCH_REGS);
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      psrc1_q   <= '0;
      psrc2_q   <= '0;
      pdst_q    <= '0;
      old_q     <= '0;
      has_dst_q <= 1'b0;
    end else begin
      rat_q     <= rat_d;
      fl_q      <= fl_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      psrc1_q   <= psrc1_d;
      psrc2_q   <= psrc2_d;
      pdst_q    <= pdst_d;
      old_q     <= old_d;
      has_dst_q <= has_dst_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_psrc1    = psrc1_q;
  assign out_psrc2    = psrc2_q;
  assign out_pdst     = pdst_q;
  assign out_old_pdst = old_q;
  assign out_has_dst  = has_dst_q;
  assign free_count   = count_q;
  assign fl_overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rename_stage.sv
// ============================================================================
//  Module   : tb_rename_stage
//  Purpose  : Directed, table-driven bench for rename_stage with hand-written
//             sequences for free-list exhaustion, retire/allocate overlap,
//             overflow and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rename_stage;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] srcReg1, srcReg2, destReg;
  logic       regWrite;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_psrc1, out_psrc2, out_pdst, out_old_pdst;
  logic       out_has_dst;
  logic       retire_valid;
  logic [5:0] retire_pdst;
  logic [6:0] free_count;
  logic       fl_overflow;

  int n_cmp;
  int n_fail;

  rename_stage #(.NUM_PREGS(64), .PREG_W(6)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .srcReg1      (srcReg1),
    .srcReg2      (srcReg2),
    .destReg      (destReg),
    .regWrite     (regWrite),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_psrc1    (out_psrc1),
    .out_psrc2    (out_psrc2),
    .out_pdst     (out_pdst),
    .out_old_pdst (out_old_pdst),
    .out_has_dst  (out_has_dst),
    .retire_valid (retire_valid),
    .retire_pdst  (retire_pdst),
    .free_count   (free_count),
    .fl_overflow  (fl_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] s1, s2, d;
    logic       rw, ordy;
    logic       e_rdy, e_ov;
    logic [5:0] e_ps1, e_ps2, e_pd, e_old;
    logic       e_hd;
    logic [6:0] e_fc;
  } vec_t;

  vec_t vt [12];

  function automatic vec_t mk(input logic iv, input int s1, input int s2, input int d,
                              input logic rw, input logic ordy, input logic e_rdy,
                              input logic e_ov, input int ps1, input int ps2, input int pd,
                              input int old, input logic hd, input int fc);
    vec_t v;
    v.iv = iv; v.s1 = 5'(s1); v.s2 = 5'(s2); v.d = 5'(d); v.rw = rw; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ps1 = 6'(ps1); v.e_ps2 = 6'(ps2);
    v.e_pd = 6'(pd); v.e_old = 6'(old); v.e_hd = hd; v.e_fc = 7'(fc);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge.
  task automatic drive(input logic iv, input int s1, input int s2, input int d,
                       input logic rw, input logic ordy, input logic rv, input int rp);
    in_valid = iv; srcReg1 = 5'(s1); srcReg2 = 5'(s2); destReg = 5'(d);
    regWrite = rw; out_ready = ordy; retire_valid = rv; retire_pdst = 6'(rp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string n, input int ps1, input int ps2, input int pd,
                         input int old, input int hd);
    chk({n, "_ps1"}, int'(out_psrc1), ps1);
    chk({n, "_ps2"}, int'(out_psrc2), ps2);
    chk({n, "_pd"},  int'(out_pdst), pd);
    chk({n, "_old"}, int'(out_old_pdst), old);
    chk({n, "_hd"},  int'(out_has_dst), hd);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //              iv s1 s2 d  rw or  rdy ov ps1 ps2 pd  old hd fc
    vt[0]  = mk(1, 1, 2, 3, 1, 1,  1, 1, 1,  2,  32, 3,  1, 31);
    vt[1]  = mk(1, 3, 3, 4, 1, 1,  1, 1, 32, 32, 33, 4,  1, 30);
    vt[2]  = mk(1, 4, 0, 0, 1, 1,  1, 1, 33, 0,  0,  0,  0, 30);
    vt[3]  = mk(1, 5, 5, 5, 1, 1,  1, 1, 5,  5,  34, 5,  1, 29);
    vt[4]  = mk(1, 5, 1, 5, 1, 1,  1, 1, 34, 1,  35, 34, 1, 28);
    vt[5]  = mk(0, 0, 0, 0, 0, 1,  1, 0, 0,  0,  0,  0,  0, 28);
    vt[6]  = mk(1, 1, 2, 6, 1, 1,  1, 1, 1,  2,  36, 6,  1, 27);
    vt[7]  = mk(1, 6, 6, 7, 1, 0,  0, 1, 1,  2,  36, 6,  1, 27);
    vt[8]  = mk(1, 6, 6, 7, 1, 0,  0, 1, 1,  2,  36, 6,  1, 27);
    vt[9]  = mk(1, 6, 6, 7, 1, 0,  0, 1, 1,  2,  36, 6,  1, 27);
    vt[10] = mk(1, 6, 6, 7, 1, 1,  1, 1, 36, 36, 37, 7,  1, 26);
    vt[11] = mk(1, 7, 0, 8, 1, 1,  1, 1, 37, 0,  38, 8,  1, 25);

    tick; tick;
    rstn = 1'b1;
    #1;
    chk("rst_ov",  int'(out_valid), 0);
    chk_out("rst", 0, 0, 0, 0, 0);
    chk("rst_fc",  int'(free_count), 32);
    chk("rst_ovf", int'(fl_overflow), 0);
    chk("rst_rdy", int'(in_ready), 1);

    // Table-driven straight-line renaming, x0 writes and back-pressure
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].iv, vt[i].s1, vt[i].s2, vt[i].d, vt[i].rw, vt[i].ordy, 0, 0);
      #1;
      chk($sformatf("v%0d_rdy", i), int'(in_ready), int'(vt[i].e_rdy));
      tick;
      chk($sformatf("v%0d_ov", i), int'(out_valid), int'(vt[i].e_ov));
      chk($sformatf("v%0d_fc", i), int'(free_count), int'(vt[i].e_fc));
      if (vt[i].e_ov)
        chk_out($sformatf("v%0d", i), int'(vt[i].e_ps1), int'(vt[i].e_ps2),
                int'(vt[i].e_pd), int'(vt[i].e_old), int'(vt[i].e_hd));
    end

    // Drain the free list down to 10 entries: p39..p53 go to x9..x23
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, 0, 9 + k, 1, 1, 0, 0);
      tick;
      chk($sformatf("fill%0d_pd", k), int'(out_pdst), 39 + k);
      chk($sformatf("fill%0d_fc", k), int'(free_count), 24 - k);
    end

    // Retire p40 in the same cycle as an allocation: head (p54) is popped
    drive(1, 0, 0, 24, 1, 1, 1, 40);
    tick;
    chk("ovl_pd", int'(out_pdst), 54);
    chk("ovl_fc", int'(free_count), 10);

    // Empty the list: p55..p63, then the recycled p40
    for (int j = 0; j < 10; j++) begin
      drive(1, 0, 0, 25 + (j % 7), 1, 1, 0, 0);
      tick;
      chk($sformatf("drain%0d_pd", j), int'(out_pdst), (j < 9) ? 55 + j : 40);
      chk($sformatf("drain%0d_fc", j), int'(free_count), 9 - j);
    end

    // Empty: writer blocked, store still accepted
    drive(1, 0, 0, 1, 1, 1, 0, 0);
    #1;
    chk("empty_wr_rdy", int'(in_ready), 0);
    tick;
    chk("empty_wr_ov", int'(out_valid), 0);
    drive(1, 3, 4, 1, 0, 1, 0, 0);
    #1;
    chk("empty_st_rdy", int'(in_ready), 1);
    tick;
    chk("empty_st_ov", int'(out_valid), 1);
    chk("empty_st_hd", int'(out_has_dst), 0);
    chk("empty_st_pd", int'(out_pdst), 0);

    // Retire p5 while a writer waits: no same-cycle bypass
    drive(1, 0, 0, 2, 1, 1, 1, 5);
    #1;
    chk("ret5_rdy", int'(in_ready), 0);
    tick;
    chk("ret5_fc", int'(free_count), 1);
    chk("ret5_ov", int'(out_valid), 0);
    drive(1, 0, 0, 2, 1, 1, 0, 0);
    #1;
    chk("post5_rdy", int'(in_ready), 1);
    tick;
    chk_out("post5", 0, 0, 5, 2, 1);
    chk("post5_fc", int'(free_count), 0);

    // p0 retire ignored
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    tick;
    chk("p0_fc", int'(free_count), 0);

    // Fill to 64 entries, then overflow
    for (int p = 0; p < 64; p++) begin
      drive(0, 0, 0, 0, 0, 1, 1, (p % 63) + 1);
      tick;
    end
    chk("full_fc",  int'(free_count), 64);
    chk("full_ovf", int'(fl_overflow), 0);
    drive(0, 0, 0, 0, 0, 1, 1, 7);
    tick;
    chk("ovf_fc",  int'(free_count), 64);
    chk("ovf_set", int'(fl_overflow), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick;
    chk("ovf_sticky", int'(fl_overflow), 1);

    // Asynchronous reset with an instruction in flight
    drive(1, 1, 2, 3, 1, 0, 0, 0);
    tick;
    chk("pre_rst_ov", int'(out_valid), 1);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_ov",  int'(out_valid), 0);
    chk_out("arst", 0, 0, 0, 0, 0);
    chk("arst_fc",  int'(free_count), 32);
    chk("arst_ovf", int'(fl_overflow), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    #2;
    rstn = 1'b1;
    tick;
    drive(1, 1, 5, 3, 1, 1, 0, 0);
    tick;
    chk_out("after_rst0", 1, 5, 32, 3, 1);
    chk("after_rst0_fc", int'(free_count), 31);
    drive(1, 3, 0, 4, 1, 1, 0, 0);
    tick;
    chk_out("after_rst1", 32, 0, 33, 4, 1);

    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rename_stage.md
# rename_stage

Register-rename stage directly downstream of instruction decode in the out-of-order core. It accepts one decoded instruction per cycle (architectural `srcReg1`/`srcReg2`/`destReg` plus `regWrite`), translates the sources through a 32-entry register alias table (RAT), and allocates a fresh physical destination from a free-list FIFO. Renamed instructions are presented on a registered valid/ready output to dispatch. Physical registers come back to the free list on retire.

## Interface
- `NUM_PREGS`, default 64: number of physical registers; must be a power of two, at least 64.
- `PREG_W`, default 6: physical tag width, equal to log2(`NUM_PREGS`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `srcReg1`, `srcReg2`, `destReg`  in  5 each  architectural register numbers.
- `regWrite`  in  1  instruction writes `destReg`.
- `out_valid`  out  1  renamed instruction held in the output register.
- `out_ready`  in  1  dispatch consumes the output.
- `out_psrc1`, `out_psrc2`  out  `PREG_W` each  physical source tags.
- `out_pdst`  out  `PREG_W`  newly allocated physical destination; 0 when `out_has_dst`=0.
- `out_old_pdst`  out  `PREG_W`  previous mapping of `destReg`, freed at retire; 0 when `out_has_dst`=0.
- `out_has_dst`  out  1  a destination was allocated.
- `retire_valid`  in  1  return `retire_pdst` to the free list.
- `retire_pdst`  in  `PREG_W`  physical register being freed.
- `free_count`  out  `PREG_W`+1  current free-list occupancy.
- `fl_overflow`  out  1  sticky error flag: a retire arrived while the free list was full.

## Operation
- Reset: RAT[i]=i for i=0..31; the free list holds p32..p(`NUM_PREGS`-1) in ascending order, with head=0, tail=`NUM_PREGS`-32, `free_count`=`NUM_PREGS`-32. `out_valid`=0, all `out_*` tags=0, `out_has_dst`=0, `fl_overflow`=0.
- need_dst = `regWrite` && (`destReg` != 0). Register x0 is never renamed and always maps to p0.
- `in_ready` = (!`out_valid` || `out_ready`) && (!need_dst || `free_count` != 0).
- Accept = `in_valid` && `in_ready`. On accept:
  - The output register loads psrc1=RAT[`srcReg1`], psrc2=RAT[`srcReg2`]. Both lookups use the RAT value *before* this instruction's own update, so `add x5,x5,x5` reads the old x5.
  - If need_dst: pop the free-list head into pdst, capture old_pdst=RAT[`destReg`], and write RAT[`destReg`]=pdst. Set `out_has_dst`=1.
  - Otherwise: pdst=0, old_pdst=0, `out_has_dst`=0, and the free list is untouched.
  - `out_valid`=1.
- If there is no accept and `out_ready`=1, `out_valid` clears. While `out_valid`=1 and `out_ready`=0, all `out_*` outputs hold stable.
- Retire:
  - If `retire_valid` and `retire_pdst` != 0, push it at the tail.
  - A push of p0 is ignored.
  - A push while `free_count`==`NUM_PREGS` is dropped and sets `fl_overflow`.
- A push and a pop in the same cycle both occur, and `free_count` is unchanged. The pop never returns the register being pushed in that same cycle.
- Head and tail pointers are `PREG_W` bits wide and wrap modulo `NUM_PREGS`. `free_count` is `PREG_W`+1 bits wide.
- Asserting `rstn` low mid-operation immediately restores the full reset state. An in-flight output is discarded.

## Timing
- Rename latency is 1 cycle: an instruction accepted at edge N is visible on `out_*` after edge N.
- The RAT write takes effect at the accept edge. The next instruction, accepted at edge N+1, sees the new mapping with no bubble.
- Throughput is 1 instruction/cycle when `out_ready`=1 and the free list is non-empty.
- A free-list-empty stall releases one cycle after the retire push, because there is no same-cycle retire-to-allocate bypass.
- `in_ready` is combinational from `out_valid`, `out_ready`, `regWrite`, `destReg` and `free_count`. It does not depend on `in_valid`.

## Test plan
- Reset, then rename `add x3,x1,x2` -> `out_psrc1`=1, `out_psrc2`=2, `out_pdst`=32, `out_old_pdst`=3, `free_count`=31.
- Back-to-back: x3=x1+x2, then x4=x3+x3 -> second instruction has `out_psrc1`=`out_psrc2`=32 and `out_pdst`=33. Also write to x0 with `regWrite`=1 -> `out_has_dst`=0, `out_pdst`=0, `free_count` unchanged.
- Rename 32 writers with `out_ready`=1 -> `free_count`=0 and `in_ready`=0 for a writer, while a store-type instruction (`regWrite`=0) is still accepted. Retire p5 -> the next writer is accepted the following cycle with `out_pdst`=5.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `out_*` stable, RAT and `free_count` unchanged. Release -> one instruction per cycle.
- Simultaneous `retire_valid` (p40) and allocation, with `free_count`=10 -> `free_count` stays 10 and the allocated tag is the old head, not 40. Retire into a full list -> `fl_overflow`=1 and stays set.
- Assert `rstn` low mid-stream -> outputs clear asynchronously. After release, RAT is identity and the next allocation is p32.
